// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: one owner at a time, held until release/drop.
// Optional hold limit with forced revoke when RR_ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 request_i,
    input  logic [N-1:0]                 release_i,
    output logic [N-1:0]                 grant_o,
    output logic                         grant_valid_o,
    output logic [$clog2(N)-1:0]         grant_id_o,
    output logic                         timeout_o
);

    localparam int IDW = $clog2(N);
    localparam logic S_IDLE  = 1'b0;
    localparam logic S_OWNED = 1'b1;

    logic           state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           gv_q, gv_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [IDW-1:0] last_q, last_d;

    logic           end_nat;
    logic           forced;
    logic           new_grant;
    logic [N-1:0]   cand;
    logic           win_found;
    logic [IDW-1:0] win_id;

    // Natural end: owner pulses release or drops its request.
    assign end_nat = (|(grant_q & release_i)) | ~(|(grant_q & request_i));

    // The owner never competes in its own re-arbitration; it is only kept
    // when nobody else is asking.
    assign cand = (state_q == S_IDLE) ? request_i : (request_i & ~grant_q);

    // Walk downward so the closest candidate after last_q is written last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = N; k >= 1; k--) begin
            if (cand[(int'(last_q) + k) % N]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(last_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gid_d     = gid_q;
        last_d    = last_q;
        new_grant = 1'b0;
        if (state_q == S_IDLE || end_nat || forced) begin
            if (win_found) begin
                state_d   = S_OWNED;
                grant_d   = {{(N-1){1'b0}}, 1'b1} << win_id;
                gid_d     = win_id;
                last_d    = win_id;
                new_grant = 1'b1;
            end else if (state_q == S_OWNED && (|(grant_q & request_i)) && !forced) begin
                new_grant = 1'b1;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                gid_d   = '0;
            end
        end
        gv_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gv_q    <= 1'b0;
            gid_q   <= '0;
            last_q  <= IDW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          tout_q;

    // hold_q counts completed owned cycles; the MAX_HOLD-th one is revoked.
    assign forced = (state_q == S_OWNED) && !end_nat && (hold_q == HW'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (!new_grant && state_q == S_OWNED)
            hold_d = hold_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            tout_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tout_q <= forced;
        end
    end

    assign timeout_o = tout_q;
`else
    assign forced    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign grant_o       = grant_q;
    assign grant_valid_o = gv_q;
    assign grant_id_o    = gid_q;

endmodule
